// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the 8-bit sync FIFO.
// Burst-limited grants; never writes while the FIFO is full.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_wr_data,
   output logic                      grant_valid,
   output logic [$clog2(N_REQ)-1:0]  grant_id
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int CW   = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] owner;
   logic [CW-1:0]   burst_cnt;

   logic [DATA_W-1:0] data_arr [N_REQ];
   logic [N_REQ-1:0]  rot;
   logic [ID_W-1:0]   pick_off;
   logic [ID_W:0]     pick_sum;
   logic [ID_W-1:0]   pick_id;
   logic              pick_found;
   logic [ID_W-1:0]   nxt_ptr;
   logic              granted;
   logic              owner_valid;
   logic              last_beat;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   // Rotate so bit 0 is rr_ptr; the lowest set bit is the next owner.
   always_comb begin
      rot        = N_REQ'({req_valid, req_valid} >> rr_ptr);
      pick_off   = '0;
      pick_found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pick_off   = ID_W'(k);
            pick_found = 1'b1;
         end
      end
      pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
      if (pick_sum >= (ID_W+1)'(N_REQ))
         pick_sum = pick_sum - (ID_W+1)'(N_REQ);
      pick_id = pick_sum[ID_W-1:0];
   end

   assign nxt_ptr = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

   assign granted     = (state == GRANT);
   assign owner_valid = req_valid[owner];
   assign last_beat   = (burst_cnt == CW'(MAX_BURST - 1));

   assign grant_valid  = granted;
   assign grant_id     = owner;
   assign fifo_wr_en   = granted && owner_valid && !fifo_full;
   assign fifo_wr_data = fifo_wr_en ? data_arr[owner] : '0;
   assign req_ready    = (granted && !fifo_full)
                       ? (N_REQ'(1) << owner) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_found) begin
                  owner     <= pick_id;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (fifo_wr_en) begin
                  if (last_beat) begin
                     rr_ptr <= nxt_ptr;
                     state  <= IDLE;
                  end else begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end else if (!owner_valid) begin
                  rr_ptr <= nxt_ptr;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
